// File: rtl/lif_tdm_scheduler_if.sv
// Host-side bus of the LIF time-multiplexing scheduler: current writes in,
// per-visit neuron report and frame spike vector out.
interface lif_tdm_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  localparam int AW = $clog2(N_NEURONS);

  logic                 en;
  logic                 cur_wr;
  logic [AW-1:0]        cur_addr;
  logic [WIDTH-1:0]     cur_data;
  logic [AW-1:0]        slot;
  logic [WIDTH-1:0]     state_out;
  logic                 spike_out;
  logic                 out_valid;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 frame_done;

  modport master (
    output en, cur_wr, cur_addr, cur_data,
    input  slot, state_out, spike_out, out_valid, spike_vec, frame_done
  );

  modport slave (
    input  en, cur_wr, cur_addr, cur_data,
    output slot, state_out, spike_out, out_valid, spike_vec, frame_done
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Round-robin leaky integrate-and-fire scheduler: one shared datapath visits
// one neuron per enabled cycle; all outputs are registered.
module lif_tdm_scheduler #(
  parameter int N_NEURONS  = 4,
  parameter int WIDTH      = 8,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  lif_tdm_scheduler_if.slave    bus
);
  localparam int AW = $clog2(N_NEURONS);
  localparam int RW = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  localparam logic [WIDTH:0] THR = (WIDTH + 1)'(THRESHOLD);

  logic [WIDTH-1:0]     mem  [N_NEURONS];
  logic [WIDTH-1:0]     cur  [N_NEURONS];
  logic [RW-1:0]        refr [N_NEURONS];
  logic [AW-1:0]        p;
  logic [N_NEURONS-1:0] shadow;

  logic [WIDTH-1:0]     leaked;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     sum_sat;
  logic [WIDTH-1:0]     next_state;
  logic [RW-1:0]        next_refr;
  logic                 in_refr;
  logic                 spike;
  logic [N_NEURONS-1:0] shadow_next;

  always_comb begin
    in_refr     = (refr[p] != '0);
    leaked      = mem[p] - (mem[p] >> LEAK_SHIFT);
    sum         = {1'b0, leaked} + {1'b0, cur[p]};
    sum_sat     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    spike       = !in_refr && ({1'b0, sum_sat} >= THR);
    next_state  = (in_refr || spike) ? '0 : sum_sat;
    next_refr   = '0;
    if (in_refr)
      next_refr = refr[p] - RW'(1);
    else if (spike)
      next_refr = RW'(REFRACT);
    shadow_next = shadow;
    if (spike)
      shadow_next[p] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        mem[i]  <= '0;
        cur[i]  <= '0;
        refr[i] <= '0;
      end
      p              <= '0;
      shadow         <= '0;
      bus.slot       <= '0;
      bus.state_out  <= '0;
      bus.spike_out  <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.spike_vec  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      // The visit reads cur[p] combinationally, so a same-edge write only affects later visits.
      if (bus.cur_wr)
        cur[bus.cur_addr] <= bus.cur_data;
      if (bus.en) begin
        mem[p]         <= next_state;
        refr[p]        <= next_refr;
        p              <= p + AW'(1);
        bus.slot       <= p;
        bus.state_out  <= next_state;
        bus.spike_out  <= spike;
        bus.out_valid  <= 1'b1;
        if (p == AW'(N_NEURONS - 1)) begin
          bus.spike_vec  <= shadow_next;
          bus.frame_done <= 1'b1;
          shadow         <= '0;
        end else begin
          bus.frame_done <= 1'b0;
          shadow         <= shadow_next;
        end
      end else begin
        bus.spike_out  <= 1'b0;
        bus.out_valid  <= 1'b0;
        bus.frame_done <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Bench for lif_tdm_scheduler: two instances (THRESHOLD 200 and 255) share one
// stimulus stream; a reference model fills per-instance expectation queues.
module tb_lif_tdm_scheduler;
  typedef struct {
    int slot;
    int state;
    int spike;
    int fdone;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  int   m_state [2][4];
  int   m_cur   [2][4];
  int   m_refr  [2][4];
  int   m_p     [2];
  int   m_shadow[2];
  int   m_vec   [2];
  exp_t q0[$];
  exp_t q1[$];

  int   exp_s [6] = '{120, 180, 0, 0, 0, 120};
  int   exp_sp[6] = '{0, 0, 1, 0, 0, 0};
  bit   en_pat[12] = '{1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1};

  lif_tdm_scheduler_if #(.N_NEURONS(4), .WIDTH(8)) bus0 ();
  lif_tdm_scheduler_if #(.N_NEURONS(4), .WIDTH(8)) bus1 ();

  lif_tdm_scheduler #(.N_NEURONS(4), .WIDTH(8), .THRESHOLD(200), .LEAK_SHIFT(1), .REFRACT(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  lif_tdm_scheduler #(.N_NEURONS(4), .WIDTH(8), .THRESHOLD(255), .LEAK_SHIFT(1), .REFRACT(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_visit(input int k);
    int p, st, sm, sp;
    exp_t e;
    p  = m_p[k];
    sp = 0;
    if (m_refr[k][p] != 0) begin
      st = 0;
      m_refr[k][p] = m_refr[k][p] - 1;
    end else begin
      sm = m_state[k][p] - m_state[k][p] / 2 + m_cur[k][p];
      if (sm > 255) sm = 255;
      if (sm >= ((k == 0) ? 200 : 255)) begin
        sp = 1;
        st = 0;
        m_refr[k][p] = 2;
      end else begin
        st = sm;
      end
    end
    m_state[k][p] = st;
    if (sp != 0) m_shadow[k] = m_shadow[k] | (1 << p);
    e.slot  = p;
    e.state = st;
    e.spike = sp;
    e.fdone = (p == 3) ? 1 : 0;
    if (p == 3) begin
      m_vec[k]    = m_shadow[k];
      m_shadow[k] = 0;
    end
    m_p[k] = (p + 1) % 4;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_inst(input int k, input logic ov, input logic [1:0] sl,
                            input logic [7:0] st, input logic sp, input logic fd,
                            input logic [3:0] sv);
    exp_t e;
    int   pending;
    pending = (k == 0) ? q0.size() : q1.size();
    if (ov === 1'b1) begin
      if (pending == 0) begin
        chk($sformatf("i%0d_unexpected_valid", k), ov, 0);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("i%0d_slot", k), sl, e.slot);
        chk($sformatf("i%0d_state", k), st, e.state);
        chk($sformatf("i%0d_spike", k), sp, e.spike);
        chk($sformatf("i%0d_frame_done", k), fd, e.fdone);
      end
    end else begin
      chk($sformatf("i%0d_missing_valid", k), pending, 0);
      if (pending != 0) begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      chk($sformatf("i%0d_idle_spike", k), sp, 0);
      chk($sformatf("i%0d_idle_frame_done", k), fd, 0);
    end
    chk($sformatf("i%0d_spike_vec", k), sv, m_vec[k]);
  endtask

  task automatic step(input logic e, input logic w, input int a, input int d);
    bus0.en = e;  bus0.cur_wr = w;  bus0.cur_addr = 2'(a);  bus0.cur_data = 8'(d);
    bus1.en = e;  bus1.cur_wr = w;  bus1.cur_addr = 2'(a);  bus1.cur_data = 8'(d);
    if (e) begin
      model_visit(0);
      model_visit(1);
    end
    if (w) begin
      m_cur[0][a] = d;
      m_cur[1][a] = d;
    end
    @(posedge clk);
    #1;
    check_inst(0, bus0.out_valid, bus0.slot, bus0.state_out, bus0.spike_out, bus0.frame_done, bus0.spike_vec);
    check_inst(1, bus1.out_valid, bus1.slot, bus1.state_out, bus1.spike_out, bus1.frame_done, bus1.spike_vec);
  endtask

  task automatic do_reset();
    bus0.en = 1'b0;  bus0.cur_wr = 1'b0;  bus0.cur_addr = '0;  bus0.cur_data = '0;
    bus1.en = 1'b0;  bus1.cur_wr = 1'b0;  bus1.cur_addr = '0;  bus1.cur_data = '0;
    rst = 1'b1;
    #1;
    chk("rst_out_valid0", bus0.out_valid, 0);
    chk("rst_slot0", bus0.slot, 0);
    chk("rst_state0", bus0.state_out, 0);
    chk("rst_spike0", bus0.spike_out, 0);
    chk("rst_vec0", bus0.spike_vec, 0);
    chk("rst_frame_done0", bus0.frame_done, 0);
    chk("rst_out_valid1", bus1.out_valid, 0);
    chk("rst_state1", bus1.state_out, 0);
    chk("rst_vec1", bus1.spike_vec, 0);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        m_state[k][i] = 0;
        m_cur[k][i]   = 0;
        m_refr[k][i]  = 0;
      end
      m_p[k]      = 0;
      m_shadow[k] = 0;
      m_vec[k]    = 0;
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int nexp;
    int nfd;

    do_reset();

    // Integrate / spike / refractory on neuron 0
    step(0, 1, 0, 120);
    for (int j = 0; j < 24; j++) begin
      step(1, 0, 0, 0);
      if (j % 4 == 0) begin
        chk("int_state_n0", bus0.state_out, exp_s[j / 4]);
        chk("int_spike_n0", bus0.spike_out, exp_sp[j / 4]);
      end else begin
        chk("int_state_other", bus0.state_out, 0);
      end
      if (j % 4 == 3)
        chk("int_spike_vec", bus0.spike_vec, (j == 11) ? 1 : 0);
    end

    // Asynchronous reset mid-run with nonzero state
    do_reset();
    step(1, 0, 0, 0);
    chk("rst_first_valid", bus0.out_valid, 1);
    chk("rst_first_slot", bus0.slot, 0);

    // Saturation: THRESHOLD 255 instance reaches 300 -> 255 and spikes
    step(0, 1, 1, 200);
    n = 0;
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 0, 0);
      if (bus1.out_valid === 1'b1 && bus1.slot === 2'd1) begin
        if (n == 0) begin
          chk("sat_v1_state", bus1.state_out, 200);
          chk("sat_v1_spike", bus1.spike_out, 0);
          chk("thr_eq_spike", bus0.spike_out, 1);
        end else if (n == 1) begin
          chk("sat_v2_state", bus1.state_out, 0);
          chk("sat_v2_spike", bus1.spike_out, 1);
        end
        n++;
      end
    end
    chk("sat_visits", n, 2);

    // Current write in the same cycle neuron 2 is visited
    do_reset();
    step(0, 1, 2, 10);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 2, 50);
    chk("coll_slot", bus0.slot, 2);
    chk("coll_old_cur", bus0.state_out, 10);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("coll_new_cur", bus0.state_out, 55);

    // Enable gaps keep position
    do_reset();
    nexp = 0;
    nfd  = 0;
    for (int i = 0; i < 12; i++) begin
      step(en_pat[i], 0, 0, 0);
      if (en_pat[i]) begin
        chk("gap_slot", bus0.slot, nexp);
        nexp = (nexp + 1) % 4;
      end else begin
        chk("gap_valid_low", bus0.out_valid, 0);
      end
      if (bus0.frame_done === 1'b1) nfd++;
    end
    chk("gap_frames", nfd, 2);

    // Multi-neuron frame
    do_reset();
    step(0, 1, 0, 199);
    step(0, 1, 1, 210);
    step(0, 1, 2, 0);
    step(0, 1, 3, 255);
    for (int j = 0; j < 8; j++) begin
      step(1, 0, 0, 0);
      if (j == 3) begin
        chk("multi_vec_t200", bus0.spike_vec, 4'b1010);
        chk("multi_vec_t255", bus1.spike_vec, 4'b1000);
        chk("multi_frame_done", bus0.frame_done, 1);
      end
      if (j == 4) begin
        chk("multi_n0_v2_state", bus0.state_out, 0);
        chk("multi_n0_v2_spike", bus0.spike_out, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
